// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Imported by the arbiter top level.
package uart_arb_pkg;

    localparam logic [7:0] UART_LF = 8'h0A;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Core byte streams plus the uart_fifo transmit side.
// The master drives requests and FIFO status; the slave is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int NCORES = 4
);
    localparam int GW = $clog2(NCORES);

    logic [NCORES-1:0]   req_valid;
    logic [NCORES*8-1:0] req_data;
    logic [NCORES-1:0]   req_ready;
    logic                tx_fifo_full;
    logic [7:0]          tx_byte;
    logic                transmit;
    logic [GW-1:0]       grant_id;
    logic                busy;

    modport master (
        output req_valid,
        output req_data,
        output tx_fifo_full,
        input  req_ready,
        input  tx_byte,
        input  transmit,
        input  grant_id,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  tx_fifo_full,
        output req_ready,
        output tx_byte,
        output transmit,
        output grant_id,
        output busy
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating priority encoder: first requester above last, with wrap.
// Purely combinational; winner holds last when nobody requests.
module uart_rr_pick #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         any,
    output logic [W-1:0] winner
);

    logic         found;
    logic [W-1:0] sel;

    // Scan last+1 .. last+N so last itself has the lowest priority
    always_comb begin
        any    = |req;
        winner = last;
        found  = 1'b0;
        sel    = '0;
        for (int k = 1; k <= N; k++) begin
            sel = W'((int'(last) + k) % N);
            if (!found && req[sel]) begin
                winner = sel;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Grants one core exclusive use of the UART TX FIFO per line.
// Ownership ends on line feed, line-length cap or owner idle timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NCORES   = 4,
    parameter int TIMEOUT  = 1024,
    parameter int MAX_LINE = 128
) (
    input  logic clk,
    input  logic reset,
    uart_tx_arbiter_if.slave bus
);

    localparam int GW = $clog2(NCORES);
    localparam int BW = $clog2(MAX_LINE + 1);
    localparam int IW = $clog2(TIMEOUT);

    arb_state_e    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [BW-1:0] bytes_q, bytes_d;
    logic [IW-1:0] idle_q, idle_d;

    logic              pick_any;
    logic [GW-1:0]     pick_winner;
    logic              owner_valid;
    logic [7:0]        owner_data;
    logic              xfer;
    logic              release_now;
    logic [NCORES-1:0] ready_vec;
    logic [7:0]        byte_out;

    uart_rr_pick #(
        .N (NCORES)
    ) u_pick (
        .req    (bus.req_valid),
        .last   (last_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    // Select the owner's lane and gate the transfer on FIFO space
    always_comb begin
        owner_valid = 1'b0;
        owner_data  = 8'h00;
        for (int i = 0; i < NCORES; i++) begin
            if (grant_q == GW'(i)) begin
                owner_valid = bus.req_valid[i];
                owner_data  = bus.req_data[8*i +: 8];
            end
        end
        xfer      = (state_q == ARB_LOCKED) && owner_valid && !bus.tx_fifo_full;
        byte_out  = xfer ? owner_data : 8'h00;
        ready_vec = xfer ? (NCORES'(1) << grant_q) : '0;
    end

    // Next-state logic: arbitration in IDLE, line tracking in LOCKED
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        bytes_d     = bytes_q;
        idle_d      = idle_q;
        release_now = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_winner;
                    last_d  = pick_winner;
                    bytes_d = '0;
                    idle_d  = '0;
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (xfer) begin
                    bytes_d = bytes_q + BW'(1);
                    idle_d  = '0;
                    if (owner_data == UART_LF || bytes_d == BW'(MAX_LINE)) begin
                        release_now = 1'b1;
                    end
                end else if (!owner_valid) begin
                    // A blocked but valid owner is not idle, so only this path counts
                    if (idle_q == IW'(TIMEOUT - 1)) begin
                        release_now = 1'b1;
                    end else begin
                        idle_d = idle_q + IW'(1);
                    end
                end
                if (release_now) begin
                    state_d = ARB_IDLE;
                    last_d  = grant_q;
                end
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= GW'(NCORES - 1);
            bytes_q <= '0;
            idle_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            bytes_q <= bytes_d;
            idle_q  <= idle_d;
        end
    end

    assign bus.transmit  = xfer;
    assign bus.tx_byte   = byte_out;
    assign bus.req_ready = ready_vec;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (4 cores, TIMEOUT 8, MAX_LINE 4).
// Cores are modelled as byte lists that advance when their ready is seen.
module tb_uart_tx_arbiter;

    localparam int NC = 4;

    logic clk;
    logic reset;

    uart_tx_arbiter_if #(.NCORES(NC)) bus ();

    uart_tx_arbiter #(
        .NCORES   (NC),
        .TIMEOUT  (8),
        .MAX_LINE (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]    src [NC][16];
    int            len [NC];
    int            ptr [NC];
    logic [NC-1:0] rdy_seen;
    logic          full_drv;

    logic          obs_tx;
    logic [7:0]    obs_byte;
    logic [NC-1:0] obs_ready;
    logic [1:0]    obs_gid;
    logic          obs_busy;

    task automatic set_src(input int c, input logic [63:0] bytes, input int n);
        for (int k = 0; k < n; k++) src[c][k] = bytes[8*(n-1-k) +: 8];
        len[c] = n;
        ptr[c] = 0;
    endtask

    task automatic clear_src();
        for (int i = 0; i < NC; i++) begin
            len[i] = 0;
            ptr[i] = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = '0;
        bus.tx_fifo_full = 1'b0;
        full_drv = 1'b0;
        rdy_seen = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One cycle: advance accepted cores, drive inputs, sample outputs
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NC; i++) begin
            if (rdy_seen[i]) ptr[i]++;
            bus.req_valid[i] = (ptr[i] < len[i]);
            bus.req_data[8*i +: 8] = (ptr[i] < len[i]) ? src[i][ptr[i]] : 8'h00;
        end
        bus.tx_fifo_full = full_drv;
        #1;
        rdy_seen  = bus.req_ready;
        obs_tx    = bus.transmit;
        obs_byte  = bus.tx_byte;
        obs_ready = bus.req_ready;
        obs_gid   = bus.grant_id;
        obs_busy  = bus.busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = '1;
        bus.req_data = 32'h41424344;
        bus.tx_fifo_full = 1'b0;
        #2;
        checks++;
        if (bus.transmit !== 1'b0 || bus.tx_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx: got %b/%h want 0/00", bus.transmit, bus.tx_byte);
        end
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got busy %b gid %0d want 0/0", bus.busy, bus.grant_id);
        end
        do_reset();
    endtask

    task automatic test_hi();
        logic [7:0] eb [5];
        logic       ebusy [5];
        eb    = '{8'h00, 8'h68, 8'h69, 8'h0A, 8'h00};
        ebusy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        clear_src();
        do_reset();
        set_src(2, 64'h68690A, 3);
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (obs_tx !== (eb[k] != 8'h00) || obs_byte !== eb[k]) begin
                errors++;
                $display("FAIL hi_byte[%0d]: got %b/%h want %b/%h", k, obs_tx, obs_byte, eb[k] != 8'h00, eb[k]);
            end
            checks++;
            if (obs_busy !== ebusy[k]) begin
                errors++;
                $display("FAIL hi_busy[%0d]: got %b want %b", k, obs_busy, ebusy[k]);
            end
            if (k == 1) begin
                checks++;
                if (obs_gid !== 2'd2 || obs_ready !== 4'b0100) begin
                    errors++;
                    $display("FAIL hi_grant: got gid %0d ready %b want 2 0100", obs_gid, obs_ready);
                end
            end
        end
    endtask

    task automatic test_interleave();
        logic [7:0] sent [$];
        logic [7:0] e;
        clear_src();
        do_reset();
        set_src(0, 64'h410A410A410A, 6);
        set_src(1, 64'h420A420A420A, 6);
        for (int k = 0; k < 19; k++) begin
            step();
            if (obs_tx) sent.push_back(obs_byte);
        end
        checks++;
        if (sent.size() != 12) begin
            errors++;
            $display("FAIL il_count: got %0d want 12", sent.size());
        end
        for (int k = 0; k < 12 && k < sent.size(); k++) begin
            e = (k % 2 == 1) ? 8'h0A : (((k / 2) % 2 == 0) ? 8'h41 : 8'h42);
            checks++;
            if (sent[k] !== e) begin
                errors++;
                $display("FAIL il_seq[%0d]: got %h want %h", k, sent[k], e);
            end
        end
        checks++;
        if (obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL il_end_busy: got %b want 0", obs_busy);
        end
    endtask

    task automatic test_backpressure();
        clear_src();
        do_reset();
        set_src(1, 64'h4142, 2);
        step();
        step();
        checks++;
        if (obs_byte !== 8'h41 || obs_gid !== 2'd1 || obs_ready !== 4'b0010) begin
            errors++;
            $display("FAIL bp_first: got %h gid %0d rdy %b want 41 1 0010", obs_byte, obs_gid, obs_ready);
        end
        full_drv = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (obs_tx !== 1'b0 || obs_ready !== 4'b0000 || obs_busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got tx %b rdy %b busy %b want 0 0000 1", k, obs_tx, obs_ready, obs_busy);
            end
        end
        full_drv = 1'b0;
        step();
        checks++;
        if (obs_tx !== 1'b1 || obs_byte !== 8'h42) begin
            errors++;
            $display("FAIL bp_resume: got %b/%h want 1/42", obs_tx, obs_byte);
        end
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 8 || k == 9) begin
                checks++;
                if (obs_busy !== (k == 8)) begin
                    errors++;
                    $display("FAIL bp_idle_busy[%0d]: got %b want %b", k, obs_busy, k == 8);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] eb [12];
        logic       ebusy [12];
        eb    = '{8'h00, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h44};
        ebusy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        clear_src();
        do_reset();
        set_src(0, 64'h41, 1);
        set_src(3, 64'h440A, 2);
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if (obs_byte !== eb[k] || obs_busy !== ebusy[k]) begin
                errors++;
                $display("FAIL to_step[%0d]: got %h busy %b want %h busy %b", k, obs_byte, obs_busy, eb[k], ebusy[k]);
            end
        end
        checks++;
        if (obs_gid !== 2'd3 || obs_ready !== 4'b1000) begin
            errors++;
            $display("FAIL to_grant: got gid %0d rdy %b want 3 1000", obs_gid, obs_ready);
        end
    endtask

    task automatic test_max_line();
        logic [7:0] eb [12];
        logic       ebusy [12];
        eb    = '{8'h00, 8'h41, 8'h41, 8'h41, 8'h41, 8'h00,
                  8'h42, 8'h43, 8'h44, 8'h0A, 8'h00, 8'h41};
        ebusy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        clear_src();
        do_reset();
        set_src(0, 64'h414141414141, 6);
        set_src(1, 64'h4243440A, 4);
        for (int k = 0; k < 12; k++) begin
            step();
            checks++;
            if (obs_tx !== (eb[k] != 8'h00) || obs_byte !== eb[k] || obs_busy !== ebusy[k]) begin
                errors++;
                $display("FAIL ml_step[%0d]: got %b/%h busy %b want %b/%h busy %b",
                         k, obs_tx, obs_byte, obs_busy, eb[k] != 8'h00, eb[k], ebusy[k]);
            end
            if (k == 6 || k == 11) begin
                checks++;
                if (obs_gid !== ((k == 6) ? 2'd1 : 2'd0)) begin
                    errors++;
                    $display("FAIL ml_gid[%0d]: got %0d want %0d", k, obs_gid, (k == 6) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] eb [5];
        eb = '{8'h00, 8'h30, 8'h0A, 8'h00, 8'h69};
        clear_src();
        do_reset();
        set_src(2, 64'h68696A, 3);
        repeat (3) step();
        checks++;
        if (obs_byte !== 8'h69 || obs_busy !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre: got %h busy %b want 69 1", obs_byte, obs_busy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.transmit !== 1'b0 || bus.tx_byte !== 8'h00 || bus.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL ar_out: got tx %b byte %h rdy %b want 0 00 0000", bus.transmit, bus.tx_byte, bus.req_ready);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.grant_id !== 2'd0) begin
            errors++;
            $display("FAIL ar_state: got busy %b gid %0d want 0 0", bus.busy, bus.grant_id);
        end
        rdy_seen = '0;
        bus.req_valid = '0;
        set_src(0, 64'h300A, 2);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (obs_byte !== eb[k]) begin
                errors++;
                $display("FAIL ar_step[%0d]: got %h want %h", k, obs_byte, eb[k]);
            end
        end
        checks++;
        if (obs_gid !== 2'd2) begin
            errors++;
            $display("FAIL ar_regrant: got %0d want 2", obs_gid);
        end
    endtask

    initial begin
        full_drv = 1'b0;
        rdy_seen = '0;
        clear_src();
        test_reset();
        test_hi();
        test_interleave();
        test_backpressure();
        test_timeout();
        test_max_line();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
